// File: rtl/d_mem_wbuf_if.sv
// rtl/d_mem_wbuf_if.sv - CPU/memory-side signal bundle for the store write buffer
interface d_mem_wbuf_if #(
    parameter int BITS     = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
);
    logic                st_valid;
    logic [BITS-1:0]     st_addr;
    logic [BITS-1:0]     st_wdata;
    logic [3:0]          st_byte_en;
    logic                ld_valid;
    logic [BITS-1:0]     ld_addr;
    logic                flush;
    logic                stall;
    logic                ld_fwd_hit;
    logic [BITS-1:0]     ld_fwd_data;
    logic                mem_rw_;
    logic [BITS-1:0]     mem_addr;
    logic [BITS-1:0]     mem_wdata;
    logic [3:0]          mem_byte_en;
    logic [PTR_BITS:0]   count;
    logic                full;
    logic                empty;
    logic                drained;

    modport master (
        output st_valid, st_addr, st_wdata, st_byte_en, ld_valid, ld_addr, flush,
        input  stall, ld_fwd_hit, ld_fwd_data, mem_rw_, mem_addr, mem_wdata,
               mem_byte_en, count, full, empty, drained
    );

    modport slave (
        input  st_valid, st_addr, st_wdata, st_byte_en, ld_valid, ld_addr, flush,
        output stall, ld_fwd_hit, ld_fwd_data, mem_rw_, mem_addr, mem_wdata,
               mem_byte_en, count, full, empty, drained
    );
endinterface

// File: rtl/d_mem_wbuf.sv
// rtl/d_mem_wbuf.sv - store write buffer; loads own the memory port, stores drain in load-free cycles
// Optional full-word store-to-load forwarding is enabled with `define WBUF_FWD_EN.
module d_mem_wbuf #(
    parameter int BITS     = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    d_mem_wbuf_if.slave wb
);
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BITS-1:0]     r_addr [DEPTH];
    logic [BITS-1:0]     r_data [DEPTH];
    logic [3:0]          r_be   [DEPTH];
    logic [DEPTH-1:0]    r_vld;
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [PTR_BITS:0]   r_count;
    logic                r_flush_hold;

    logic                w_full, w_empty, w_flushing;
    logic                w_match, w_fwd_ok, w_ld_conflict;
    logic                w_push, w_pop, w_flush_go, w_drained;
    logic [PTR_BITS-1:0] w_slot;
    logic                w_mem_rw_;
    logic [BITS-1:0]     w_mem_addr, w_mem_wdata;
    logic [3:0]          w_mem_be;
`ifdef WBUF_FWD_EN
    logic [BITS-1:0]     w_match_data;
    logic [3:0]          w_match_be;
`endif

    assign w_full     = (r_count == (PTR_BITS+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_flushing = (r_state == S_FLUSH);

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        w_match = 1'b0;
        w_slot  = '0;
`ifdef WBUF_FWD_EN
        w_match_data = '0;
        w_match_be   = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = r_rd_ptr + PTR_BITS'(i);
            if (wb.ld_valid && r_vld[w_slot] && (r_addr[w_slot] == wb.ld_addr)) begin
                w_match = 1'b1;
`ifdef WBUF_FWD_EN
                w_match_data = r_data[w_slot];
                w_match_be   = r_be[w_slot];
`endif
            end
        end
    end

`ifdef WBUF_FWD_EN
    assign w_fwd_ok       = w_match && (w_match_be == 4'hF);
    assign wb.ld_fwd_hit  = w_fwd_ok;
    assign wb.ld_fwd_data = w_fwd_ok ? w_match_data : '0;
`else
    assign w_fwd_ok       = 1'b0;
    assign wb.ld_fwd_hit  = 1'b0;
    assign wb.ld_fwd_data = '0;
`endif

    assign w_ld_conflict = w_match && !w_fwd_ok;
    assign w_push        = wb.st_valid && !w_full && !w_ld_conflict && !w_flushing;
    assign w_flush_go    = wb.flush && !r_flush_hold;
    assign w_drained     = w_flushing && w_empty;

    // A conflicting load hands the port to the drain so the matching entry always leaves.
    always_comb begin
        w_pop       = 1'b0;
        w_mem_rw_   = 1'b1;
        w_mem_addr  = wb.ld_addr;
        w_mem_wdata = '0;
        w_mem_be    = '0;
        if (!rst && !w_empty && (w_flushing || !wb.ld_valid || w_ld_conflict)) begin
            w_pop       = 1'b1;
            w_mem_rw_   = 1'b0;
            w_mem_addr  = r_addr[r_rd_ptr];
            w_mem_wdata = r_data[r_rd_ptr];
            w_mem_be    = r_be[r_rd_ptr];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_flush_go) w_next = S_FLUSH;
                      else if (w_push) w_next = S_ACTIVE;
            S_ACTIVE: if (w_flush_go) w_next = S_FLUSH;
                      else if (w_pop && !w_push && (r_count == (PTR_BITS+1)'(1))) w_next = S_IDLE;
            S_FLUSH:  if (w_empty) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vld        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_flush_hold <= 1'b0;
        end else begin
            r_state      <= w_next;
            // A level flush that has already drained must drop before it can retrigger.
            r_flush_hold <= wb.flush && (r_flush_hold || w_drained);
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= wb.st_addr;
            r_data[r_wr_ptr] <= wb.st_wdata;
            r_be[r_wr_ptr]   <= wb.st_byte_en;
        end
    end

    assign wb.stall       = (wb.st_valid && w_full) || w_ld_conflict || w_flushing;
    assign wb.mem_rw_     = w_mem_rw_;
    assign wb.mem_addr    = w_mem_addr;
    assign wb.mem_wdata   = w_mem_wdata;
    assign wb.mem_byte_en = w_mem_be;
    assign wb.count       = r_count;
    assign wb.full        = w_full;
    assign wb.empty       = w_empty;
    assign wb.drained     = w_drained;
endmodule

// File: tb/tb_d_mem_wbuf.sv
// tb/tb_d_mem_wbuf.sv - randomized and directed bench for d_mem_wbuf against a queue-based model
module tb_d_mem_wbuf;
    localparam int BITS = 32, DEPTH = 4, PTR_BITS = 2, VW = 141;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    d_mem_wbuf_if #(.BITS(BITS), .DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) bus ();
    d_mem_wbuf #(.BITS(BITS), .DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
        .clk(clk), .rst(rst), .wb(bus)
    );

    st_t          q[$];
    bit [31:0]    mem[bit [31:0]];
    bit [31:0]    mmem[bit [31:0]];
    bit [31:0]    arch[bit [31:0]];
    bit           m_flushing, m_hold, last_accept, cyc_rst, ld_chk;
    logic [VW-1:0] obs_v, exp_v;
    logic         obs_rw, obs_stall, obs_drained;
    logic [31:0]  obs_addr, obs_ld;
    int           checks = 0, errors = 0, dut_writes = 0;

    function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] nw, bit [3:0] be);
        bit [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic set_inputs(bit sv, bit [31:0] sa, bit [31:0] sd, bit [3:0] sb,
                              bit lv, bit [31:0] la, bit fl);
        bus.st_valid = sv; bus.st_addr = sa; bus.st_wdata = sd; bus.st_byte_en = sb;
        bus.ld_valid = lv; bus.ld_addr = la; bus.flush = fl;
    endtask

    // One clock: observe DUT at negedge, predict from the queue model, advance the model.
    task automatic model_cycle();
        int mi;
        bit fwd, conflict, e_stall, drain, accept, pre_empty;
        st_t h;
        logic [31:0] e_fwd, e_ld;
        @(negedge clk);
        cyc_rst     = rst;
        obs_rw      = bus.mem_rw_;
        obs_stall   = bus.stall;
        obs_drained = bus.drained;
        obs_addr    = bus.mem_addr;
        obs_ld      = bus.ld_fwd_hit ? bus.ld_fwd_data : mem[bus.ld_addr];
        if (bus.mem_rw_ == 1'b0) begin
            dut_writes++;
            mem[bus.mem_addr] = merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_byte_en);
        end
        if (rst) begin
            q.delete();
            m_flushing = 0; m_hold = 0; ld_chk = 0; last_accept = 0;
            arch = mmem;
            obs_v = '0; exp_v = '0;
        end else begin
            mi = -1;
            if (bus.ld_valid)
                for (int i = q.size() - 1; i >= 0; i--)
                    if (q[i].addr == bus.ld_addr) begin mi = i; break; end
            fwd = 0;
`ifdef WBUF_FWD_EN
            fwd = (mi >= 0) && (q[mi].be == 4'hF);
`endif
            e_fwd = 32'h0;
            if (fwd) e_fwd = q[mi].data;
            conflict  = (mi >= 0) && !fwd;
            e_stall   = (bus.st_valid && q.size() == DEPTH) || conflict || m_flushing;
            pre_empty = (q.size() == 0);
            if (m_flushing)                       drain = !pre_empty;
            else if (bus.ld_valid && !conflict)   drain = 0;
            else                                  drain = !pre_empty;
            h = pre_empty ? st_t'(0) : q[0];
            ld_chk = bus.ld_valid && !e_stall;
            e_ld   = ld_chk ? arch[bus.ld_addr] : 32'h0;
            exp_v = {e_stall, !drain, drain ? h.addr : bus.ld_addr,
                     drain ? h.data : 32'h0, drain ? h.be : 4'h0, 3'(q.size()),
                     q.size() == DEPTH, pre_empty, m_flushing && pre_empty,
                     fwd, e_fwd, e_ld};
            obs_v = {bus.stall, bus.mem_rw_, bus.mem_addr,
                     bus.mem_rw_ ? 32'h0 : bus.mem_wdata, bus.mem_rw_ ? 4'h0 : bus.mem_byte_en,
                     bus.count, bus.full, bus.empty, bus.drained,
                     bus.ld_fwd_hit, bus.ld_fwd_data, ld_chk ? obs_ld : 32'h0};
            accept = bus.st_valid && (q.size() < DEPTH) && !conflict && !m_flushing;
            if (drain) begin
                mmem[h.addr] = merge(mmem[h.addr], h.data, h.be);
                void'(q.pop_front());
            end
            if (accept) begin
                q.push_back({bus.st_addr, bus.st_wdata, bus.st_byte_en});
                arch[bus.st_addr] = merge(arch[bus.st_addr], bus.st_wdata, bus.st_byte_en);
            end
            last_accept = accept;
            if (m_flushing) begin
                if (pre_empty) begin m_flushing = 0; m_hold = bus.flush; end
            end else if (bus.flush && !m_hold) m_flushing = 1;
            if (!bus.flush) m_hold = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            model_cycle();
            checks++;
            if (obs_rw !== 1'b1) begin errors++; $display("FAIL reset_rw got %b exp 1", obs_rw); end
        end
        rst = 0;
        model_cycle();
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_state got %h exp %h", obs_v, exp_v); end
        checks++;
        if ({bus.stall, bus.mem_rw_, bus.drained, bus.ld_fwd_hit, bus.count, bus.empty, bus.full}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b rw=%b drained=%b hit=%b count=%0d empty=%b full=%b exp 0 1 0 0 0 1 0",
                     bus.stall, bus.mem_rw_, bus.drained, bus.ld_fwd_hit, bus.count, bus.empty, bus.full);
        end
    endtask

    task automatic test_three_stores();
        bit [31:0] addrs[3] = '{32'h10, 32'h14, 32'h18};
        bit [31:0] datas[3] = '{32'h11, 32'h22, 32'h33};
        int w0 = dut_writes;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) set_inputs(1, addrs[k], datas[k], 4'hF, 0, 0, 0);
            else       set_inputs(0, 0, 0, 0, 0, 0, 0);
            model_cycle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL three_stores c%0d got %h exp %h", k, obs_v, exp_v); end
        end
        checks++;
        if (dut_writes - w0 !== 3 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL three_stores_total got writes=%0d empty=%b exp 3 1", dut_writes - w0, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = dut_writes, tries = 0;
        bit first_stall = 0;
        for (int k = 0; k < 4; k++) begin
            set_inputs(1, 32'h40 + 4*k, 32'h500 + k, 4'hF, 1, 32'h1000, 0);
            model_cycle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_fill c%0d got %h exp %h", k, obs_v, exp_v); end
        end
        set_inputs(1, 32'h50, 32'h504, 4'hF, 0, 0, 0);
        do begin
            model_cycle();
            if (tries == 0) first_stall = obs_stall;
            tries++;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_fifth t%0d got %h exp %h", tries, obs_v, exp_v); end
        end while (!last_accept && tries < 10);
        checks++;
        if (tries !== 2 || first_stall !== 1'b1) begin
            errors++; $display("FAIL b2b_stall got tries=%0d stall=%b exp 2 1", tries, first_stall);
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            model_cycle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_drain c%0d got %h exp %h", k, obs_v, exp_v); end
        end
        checks++;
        if (dut_writes - w0 !== 5) begin errors++; $display("FAIL b2b_writes got %0d exp 5", dut_writes - w0); end
    endtask

    task automatic load_after_store(string name, bit [31:0] data, bit [3:0] be,
                                    int exp_stalls, bit [31:0] exp_data);
        int stalls = 0, tries = 0;
        set_inputs(1, 32'h20, data, be, 0, 0, 0);
        model_cycle();
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL %s_store got %h exp %h", name, obs_v, exp_v); end
        set_inputs(0, 0, 0, 0, 1, 32'h20, 0);
        do begin
            model_cycle();
            tries++;
            if (obs_stall) stalls++;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL %s_load t%0d got %h exp %h", name, tries, obs_v, exp_v); end
        end while (obs_stall && tries < 10);
        checks++;
        if (stalls !== exp_stalls || obs_ld !== exp_data) begin
            errors++; $display("FAIL %s_result got stalls=%0d data=%h exp %0d %h", name, stalls, obs_ld, exp_stalls, exp_data);
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) model_cycle();
    endtask

    task automatic test_raw();
`ifdef WBUF_FWD_EN
        load_after_store("raw", 32'hAB, 4'hF, 0, 32'hAB);
`else
        load_after_store("raw", 32'hAB, 4'hF, 1, 32'hAB);
`endif
    endtask

    task automatic test_partial();
        load_after_store("partial", 32'h000000CD, 4'h1, 1, 32'h000000CD);
    endtask

    task automatic test_loads_block();
        int w0 = dut_writes;
        for (int k = 0; k < 6; k++) begin
            if (k < 2) set_inputs(1, 32'h60 + 4*k, 32'h61 + k, 4'hF, 1, 32'h3000, 0);
            else       set_inputs(0, 0, 0, 0, 1, 32'h3000, 0);
            model_cycle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL ldblock c%0d got %h exp %h", k, obs_v, exp_v); end
        end
        checks++;
        if (dut_writes - w0 !== 0) begin errors++; $display("FAIL ldblock_nowrite got %0d exp 0", dut_writes - w0); end
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        model_cycle();
        checks++;
        if (obs_rw !== 1'b0 || obs_addr !== 32'h60) begin
            errors++; $display("FAIL ldblock_pop got rw=%b addr=%h exp 0 00000060", obs_rw, obs_addr);
        end
        for (int k = 0; k < 3; k++) model_cycle();
    endtask

    task automatic fill3(bit [31:0] base);
        for (int k = 0; k < 3; k++) begin
            set_inputs(1, base + 4*k, base + 32'h100 + k, 4'hF, 1, 32'h4000, 0);
            model_cycle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL fill c%0d got %h exp %h", k, obs_v, exp_v); end
        end
    endtask

    task automatic test_flush();
        int pulses = 0, stall_drains = 0, w0;
        fill3(32'h80);
        set_inputs(0, 0, 0, 0, 1, 32'h4000, 1);
        for (int k = 0; k < 10; k++) begin
            model_cycle();
            if (obs_drained) pulses++;
            if (obs_stall && !obs_rw) stall_drains++;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL flush c%0d got %h exp %h", k, obs_v, exp_v); end
        end
        checks++;
        if (pulses !== 1 || stall_drains !== 3) begin
            errors++; $display("FAIL flush_counts got pulses=%0d stalled_drains=%0d exp 1 3", pulses, stall_drains);
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        model_cycle();
        fill3(32'h90);
        set_inputs(0, 0, 0, 0, 0, 0, 1);
        model_cycle();
        model_cycle();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        model_cycle();
        checks++;
        if (obs_rw !== 1'b1) begin errors++; $display("FAIL flush_rst_rw got %b exp 1", obs_rw); end
        rst = 0;
        w0 = dut_writes;
        for (int k = 0; k < 5; k++) begin
            model_cycle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL post_rst c%0d got %h exp %h", k, obs_v, exp_v); end
        end
        checks++;
        if (dut_writes - w0 !== 0 || bus.count !== 3'd0) begin
            errors++; $display("FAIL post_rst_state got writes=%0d count=%0d exp 0 0", dut_writes - w0, bus.count);
        end
    endtask

    task automatic test_random();
        bit [31:0] addrs[5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h2FC};
        bit fl = 0;
        for (int k = 0; k < 420; k++) begin
            if (k < 400) begin
                if (!fl) fl = ($urandom_range(0, 24) == 0);
                else     fl = ($urandom_range(0, 2) != 0);
                set_inputs($urandom_range(0, 1), addrs[$urandom_range(0, 3)], $urandom,
                           $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(1, 15)),
                           $urandom_range(0, 1), addrs[$urandom_range(0, 4)], fl);
            end else set_inputs(0, 0, 0, 0, 0, 0, 0);
            model_cycle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random c%0d got %h exp %h", k, obs_v, exp_v); end
        end
    endtask

    initial begin
        rst = 1;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_three_stores();
        test_back_to_back();
        test_raw();
        test_partial();
        test_loads_block();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
